// File: rtl/osd_stm_riscv_capture_if.sv
// osd_stm_riscv_capture_if
//   Bundles the signals between the core retire/writeback port, the STM
//   trace input and the capture stage.
//   master : core/STM side. Drives retire, writeback and trace_reg_* and
//            observes the serialised trace stream and drop_count.
//   slave  : the capture stage. Consumes retire/writeback/trace_reg_* and
//            drives trace_valid/trace_id/trace_value/drop_count.
interface osd_stm_riscv_capture_if #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned REG_ADDR_WIDTH = 5
);
    logic [1:0]                retire_valid;
    logic [31:0]               retire_insn0;
    logic [31:0]               retire_insn1;
    logic [1:0]                wb_valid;
    logic [REG_ADDR_WIDTH-1:0] wb_addr0;
    logic [REG_ADDR_WIDTH-1:0] wb_addr1;
    logic [XLEN-1:0]           wb_data0;
    logic [XLEN-1:0]           wb_data1;
    logic                      trace_reg_enable;
    logic [REG_ADDR_WIDTH-1:0] trace_reg_addr;
    logic                      trace_valid;
    logic [15:0]               trace_id;
    logic [XLEN-1:0]           trace_value;
    logic [15:0]               drop_count;

    modport master (
        output retire_valid, retire_insn0, retire_insn1,
        output wb_valid, wb_addr0, wb_addr1, wb_data0, wb_data1,
        output trace_reg_enable, trace_reg_addr,
        input  trace_valid, trace_id, trace_value, drop_count
    );

    modport slave (
        input  retire_valid, retire_insn0, retire_insn1,
        input  wb_valid, wb_addr0, wb_addr1, wb_data0, wb_data1,
        input  trace_reg_enable, trace_reg_addr,
        output trace_valid, trace_id, trace_value, drop_count
    );
endinterface

// File: rtl/osd_stm_riscv_capture.sv
// osd_stm_riscv_capture
//   Snoops a dual-issue RISC-V retire/writeback port, detects software trace
//   markers (addi x0, x0, imm with imm != 0) and pairs each one with the
//   current value of the register selected by the STM. Up to two events per
//   cycle are queued in a small FIFO and replayed to the STM at one event
//   per cycle (the STM has no back-pressure).
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset
//     bus  - slave side of osd_stm_riscv_capture_if:
//            retire_valid/retire_insn0/1 : retired instructions (slot 0 older)
//            wb_valid/wb_addr0/1/wb_data0/1 : same-cycle register writebacks
//            trace_reg_enable/trace_reg_addr : capture enable and tracked reg
//            trace_valid/trace_id/trace_value : event stream to the STM
//            drop_count : saturating count of events lost to a full queue
module osd_stm_riscv_capture #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    osd_stm_riscv_capture_if.slave   bus
);

    localparam int unsigned IDX_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W   = IDX_W + 1;
    localparam int unsigned ENTRY_W = 16 + XLEN;

    typedef logic [ENTRY_W-1:0] entry_t;

    // addi x0, x0, imm with a non-zero immediate; imm == 0 is the canonical NOP
    function automatic logic is_marker(input logic [31:0] insn);
        return (insn[6:0]   == 7'b0010011) &&
               (insn[14:12] == 3'b000)     &&
               (insn[11:7]  == 5'd0)       &&
               (insn[19:15] == 5'd0)       &&
               (insn[31:20] != 12'd0);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [XLEN-1:0]   shadow;
    logic [15:0]       drop_q;

    // ------------------------------------------------------------------
    // Marker decode and value forwarding
    // ------------------------------------------------------------------
    logic              mark0;
    logic              mark1;
    logic              fwd0_hit;
    logic              fwd1_hit;
    logic [XLEN-1:0]   val1;
    entry_t            ev_a;
    entry_t            ev_b;
    logic [1:0]        n_ev;

    always_comb begin
        mark0    = bus.trace_reg_enable & bus.retire_valid[0] & is_marker(bus.retire_insn0);
        mark1    = bus.trace_reg_enable & bus.retire_valid[1] & is_marker(bus.retire_insn1);

        fwd0_hit = bus.wb_valid[0] && (bus.wb_addr0 == bus.trace_reg_addr) &&
                   (bus.trace_reg_addr != '0);
        fwd1_hit = bus.wb_valid[1] && (bus.wb_addr1 == bus.trace_reg_addr) &&
                   (bus.trace_reg_addr != '0);

        // Slot 1 sees the older slot's same-cycle write; slot 0 sees only the
        // pre-edge shadow. Neither slot sees its own write (markers write x0).
        val1     = fwd0_hit ? bus.wb_data0 : shadow;

        // Events are compacted so the first accepted one is always ev_a;
        // when only slot 1 carries a marker it moves into ev_a.
        ev_a     = mark0 ? {4'b0, bus.retire_insn0[31:20], shadow}
                         : {4'b0, bus.retire_insn1[31:20], val1};
        ev_b     = {4'b0, bus.retire_insn1[31:20], val1};
        n_ev     = 2'(mark0) + 2'(mark1);
    end

    // ------------------------------------------------------------------
    // FIFO occupancy, admission and drop accounting
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  count;
    logic              pop;
    logic [PTR_W-1:0]  occ_after;
    logic [PTR_W-1:0]  free_slots;
    logic [1:0]        n_push;
    logic [1:0]        n_drop;
    logic [16:0]       drop_sum;
    logic [15:0]       drop_next;

    always_comb begin
        count      = wr_ptr - rd_ptr;
        pop        = (count != '0);
        // The head leaves at the same edge, so its slot is already free
        occ_after  = count - PTR_W'(pop);
        free_slots = PTR_W'(FIFO_DEPTH) - occ_after;

        n_push = 2'd0;
        if (n_ev == 2'd2 && free_slots >= PTR_W'(2)) begin
            n_push = 2'd2;
        end else if (n_ev != 2'd0 && free_slots != '0) begin
            n_push = 2'd1;
        end
        n_drop    = n_ev - n_push;

        drop_sum  = 17'(drop_q) + 17'(n_drop);
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            shadow <= '0;
            drop_q <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            drop_q <= drop_next;
            // Youngest matching write wins; register 0 never updates
            if (fwd1_hit) begin
                shadow <= bus.wb_data1;
            end else if (fwd0_hit) begin
                shadow <= bus.wb_data0;
            end
        end
    end

    // Storage carries no reset: entries are only visible through the pointers
    logic [IDX_W-1:0] wr_idx0;
    logic [IDX_W-1:0] wr_idx1;

    always_comb begin
        wr_idx0 = wr_ptr[IDX_W-1:0];
        wr_idx1 = wr_ptr[IDX_W-1:0] + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (n_push != 2'd0) begin
                mem[wr_idx0] <= ev_a;
            end
            if (n_push == 2'd2) begin
                mem[wr_idx1] <= ev_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head of queue, zeroed while empty
    // ------------------------------------------------------------------
    entry_t head;

    always_comb begin
        head = mem[rd_ptr[IDX_W-1:0]];
    end

    assign bus.trace_valid = pop;
    assign bus.trace_id    = pop ? head[ENTRY_W-1:XLEN] : '0;
    assign bus.trace_value = pop ? head[XLEN-1:0]       : '0;
    assign bus.drop_count  = drop_q;

endmodule
